// File: rtl/display_scan_mux_pkg.sv
// Shared constants and types for the 7-segment scan multiplexer.
// Build option: LEADING_ZERO_BLANK_EN enables leading-zero suppression in display_scan_mux.
package display_scan_mux_pkg;

    localparam int SCAN_NUM_DIGITS_DEFAULT = 4;
    localparam int SCAN_PRESCALE_DEFAULT   = 50000;
    localparam int SCAN_BLANK_DEFAULT      = 16;
    localparam int BCD_WIDTH               = 4;

    typedef logic [BCD_WIDTH-1:0] bcd_t;

endpackage

// File: rtl/display_scan_mux_if.sv
// Digit-value inputs and display-drive outputs of the scan multiplexer.
// master = digit source / observer, slave = the scanner.
interface display_scan_mux_if #(
    parameter int NUM_DIGITS = display_scan_mux_pkg::SCAN_NUM_DIGITS_DEFAULT
);
    logic                                          en;
    logic [display_scan_mux_pkg::BCD_WIDTH*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]                         dp_in;
    logic [display_scan_mux_pkg::BCD_WIDTH-1:0]    bcd_out;
    logic [NUM_DIGITS-1:0]                         an;
    logic                                          dp_out;
    logic                                          frame_tick;

    modport master (
        output en, digits, dp_in,
        input  bcd_out, an, dp_out, frame_tick
    );

    modport slave (
        input  en, digits, dp_in,
        output bcd_out, an, dp_out, frame_tick
    );
endinterface

// File: rtl/display_scan_mux_scan_prescaler.sv
// Per-slot cycle counter: produces slot boundaries and the dead-time window
// at the start of each slot.
module scan_prescaler #(
    parameter int PRESCALE     = display_scan_mux_pkg::SCAN_PRESCALE_DEFAULT,
    parameter int BLANK_CYCLES = display_scan_mux_pkg::SCAN_BLANK_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic slot_start,
    output logic slot_end,
    output logic in_blank
);
    localparam int CW = $clog2(PRESCALE);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (en) begin
            if (cnt_reg == CW'(PRESCALE - 1)) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign slot_start = (cnt_reg == '0);
    assign slot_end   = en && (cnt_reg == CW'(PRESCALE - 1));
    assign in_blank   = (cnt_reg < CW'(BLANK_CYCLES));

endmodule

// File: rtl/display_scan_mux.sv
// Time-multiplexed 7-segment scanner: frame snapshot, digit index and output muxing.
// Build option: define LEADING_ZERO_BLANK_EN to suppress leading zero digits.
module display_scan_mux
    import display_scan_mux_pkg::*;
#(
    parameter int NUM_DIGITS   = SCAN_NUM_DIGITS_DEFAULT,
    parameter int PRESCALE     = SCAN_PRESCALE_DEFAULT,
    parameter int BLANK_CYCLES = SCAN_BLANK_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    display_scan_mux_if.slave        bus
);
    localparam int IW = $clog2(NUM_DIGITS);

    logic                            slot_start;
    logic                            slot_end;
    logic                            in_blank;

    logic [IW-1:0]                   idx_reg;
    logic [BCD_WIDTH*NUM_DIGITS-1:0] snap_d_reg;
    logic [NUM_DIGITS-1:0]           snap_dp_reg;
    logic                            frame_tick_reg;
    logic                            active_reg;

    logic                            snap_take;
    logic [NUM_DIGITS-1:0]           suppress_mask;
    logic [NUM_DIGITS-1:0]           an_onehot;
    bcd_t                            nib [NUM_DIGITS];
    logic                            show;

    scan_prescaler #(
        .PRESCALE     (PRESCALE),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_prescaler (
        .clk        (clk),
        .rst        (rst),
        .en         (bus.en),
        .slot_start (slot_start),
        .slot_end   (slot_end),
        .in_blank   (in_blank)
    );

    // The snapshot is taken only at the very start of a frame so a frame never mixes old and new digits.
    assign snap_take = bus.en && slot_start && (idx_reg == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_reg        <= '0;
            snap_d_reg     <= '0;
            snap_dp_reg    <= '0;
            frame_tick_reg <= 1'b0;
            active_reg     <= 1'b0;
        end else begin
            active_reg     <= bus.en;
            frame_tick_reg <= slot_end && (idx_reg == IW'(NUM_DIGITS - 1));
            if (snap_take) begin
                snap_d_reg  <= bus.digits;
                snap_dp_reg <= bus.dp_in;
            end
            if (slot_end) begin
                if (idx_reg == IW'(NUM_DIGITS - 1)) begin
                    idx_reg <= '0;
                end else begin
                    idx_reg <= idx_reg + 1'b1;
                end
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS:0]   zero_above;
    logic [NUM_DIGITS-1:0] lz_mask_next;
    logic [NUM_DIGITS-1:0] lz_mask_reg;

    // zero_above[k]: digit k and every digit above it are zero; digit 0 is always shown.
    assign zero_above[NUM_DIGITS] = 1'b1;
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
        assign zero_above[gi]   = (bus.digits[BCD_WIDTH*gi +: BCD_WIDTH] == '0) && zero_above[gi+1];
        assign lz_mask_next[gi] = (gi != 0) && zero_above[gi];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lz_mask_reg <= '0;
        end else if (snap_take) begin
            lz_mask_reg <= lz_mask_next;
        end
    end

    assign suppress_mask = lz_mask_reg;
`else
    assign suppress_mask = '0;
`endif

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        assign nib[gi]       = snap_d_reg[BCD_WIDTH*gi +: BCD_WIDTH];
        assign an_onehot[gi] = (idx_reg == IW'(gi));
    end

    // active_reg is the registered enable, so blanking on en=0 never depends on the live input.
    assign show = active_reg && !in_blank && !suppress_mask[idx_reg];

    assign bus.bcd_out    = nib[idx_reg];
    assign bus.an         = show ? an_onehot : '0;
    assign bus.dp_out     = show && snap_dp_reg[idx_reg];
    assign bus.frame_tick = frame_tick_reg;

endmodule
